sparkles: RTL and testbench

SPARKLES -- requirements
Module: sparkles

---
 rtl/sparkles_pkg.sv | 45 ++++
 rtl/sparkles_pixel.sv | 30 +++
 rtl/sparkles.sv | 81 ++++++++
 tb/tb_sparkles.sv | 122 ++++++++++++
 4 files changed

// File: rtl/sparkles_pkg.sv
// Shared constants for the sparkles sprite ROM: sprite geometry, ROM size
// and the per-frame arm length (R) and diagonal length (D) tables.
package sparkles_pkg;

    localparam int SPR_DIM      = 20;
    localparam int SPR_CENTRE   = 9;
    localparam int FRAME_PIXELS = 400;
    localparam int NUM_FRAMES   = 4;
    localparam int ROM_DEPTH    = 4096;
    localparam int ADDR_W       = 12;
    localparam int COORD_W      = 5;
    localparam int FRAME_W      = 2;

    // Highest address that holds sprite data, plus one.
    localparam int DATA_END = NUM_FRAMES * FRAME_PIXELS;

    // Arm half-length R for each frame.
    function automatic logic [COORD_W-1:0] frame_arm(input logic [FRAME_W-1:0] f);
        logic [COORD_W-1:0] r;
        r = 5'd3;
        case (f)
            2'd0: r = 5'd3;
            2'd1: r = 5'd6;
            2'd2: r = 5'd9;
            2'd3: r = 5'd4;
            default: r = 5'd3;
        endcase
        return r;
    endfunction

    // Diagonal half-length D for each frame.
    function automatic logic [COORD_W-1:0] frame_diag(input logic [FRAME_W-1:0] f);
        logic [COORD_W-1:0] d;
        d = 5'd1;
        case (f)
            2'd0: d = 5'd1;
            2'd1: d = 5'd3;
            2'd2: d = 5'd5;
            2'd3: d = 5'd2;
            default: d = 5'd1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sparkles_pixel.sv
// Combinational sparkle pattern: lit when on the vertical/horizontal arm
// (length R) or on a diagonal (length D) around the sprite centre.
// Ports: frame_i (frame 0..3), x_i / y_i (0..19), lit_o (pixel on).
module sparkles_pixel
    import sparkles_pkg::*;
(
    input  logic [FRAME_W-1:0] frame_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               lit_o
);

    localparam logic [COORD_W-1:0] CTR = COORD_W'(SPR_CENTRE);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W-1:0] arm;
    logic [COORD_W-1:0] diag;

    always_comb begin
        dx    = (x_i >= CTR) ? (x_i - CTR) : (CTR - x_i);
        dy    = (y_i >= CTR) ? (y_i - CTR) : (CTR - y_i);
        arm   = frame_arm(frame_i);
        diag  = frame_diag(frame_i);
        lit_o = ((dx == '0) && (dy <= arm))
              | ((dy == '0) && (dx <= arm))
              | ((dx == dy) && (dx <= diag));
    end

endmodule

// File: rtl/sparkles.sv
// Read-only 4096x1 sparkle sprite ROM: 4 frames of 20x20 pixels at
// addresses 0..1599, zero elsewhere. One-edge read latency; define
// SPARKLES_OUT_REG_EN to add a second output register (latency 2).
// Ports: clock (read clock), reset (async, active high),
//        address (12-bit linear address), q (pixel, 1 = lit).
module sparkles
    import sparkles_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    output logic              q
);

    localparam logic [ADDR_W-1:0] FP = ADDR_W'(FRAME_PIXELS);

    logic [FRAME_W-1:0] frame;
    logic [ADDR_W-1:0]  base;
    logic [8:0]         p;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               in_range;
    logic               lit;
    logic               q_d;
    logic               q_q;

    // Frame by range compare avoids a full 12-bit divider.
    always_comb begin
        frame = 2'd0;
        base  = '0;
        if (address >= 3 * FP) begin
            frame = 2'd3;
            base  = 3 * FP;
        end else if (address >= 2 * FP) begin
            frame = 2'd2;
            base  = 2 * FP;
        end else if (address >= FP) begin
            frame = 2'd1;
            base  = FP;
        end
        // Pixel index is < 400 whenever in range, so 9 bits suffice.
        p        = 9'(address - base);
        y        = COORD_W'(p / 9'(SPR_DIM));
        x        = COORD_W'(p % 9'(SPR_DIM));
        in_range = address < ADDR_W'(DATA_END);
    end

    sparkles_pixel u_pixel (
        .frame_i (frame),
        .x_i     (x),
        .y_i     (y),
        .lit_o   (lit)
    );

    assign q_d = in_range & lit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

`ifdef SPARKLES_OUT_REG_EN
    logic q2_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q2_q <= 1'b0;
        end else begin
            q2_q <= q_q;
        end
    end

    assign q = q2_q;
`else
    assign q = q_q;
`endif

endmodule

// File: tb/tb_sparkles.sv
// Self-checking bench for sparkles: directed corner addresses, reset
// behaviour, full sweep of the data region and random addresses.
module tb_sparkles;

    logic        clock;
    logic        reset;
    logic [11:0] address;
    logic        q;

    int checks;
    int errors;

    sparkles dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .q       (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference pattern straight from the sprite rules.
    function automatic logic model(input int a);
        int rr[4];
        int dd[4];
        int f, p, x, y, dx, dy;
        rr = '{3, 6, 9, 4};
        dd = '{1, 3, 5, 2};
        if (a >= 1600) return 1'b0;
        f  = a / 400;
        p  = a % 400;
        y  = p / 20;
        x  = p % 20;
        dx = (x > 9) ? x - 9 : 9 - x;
        dy = (y > 9) ? y - 9 : 9 - y;
        return ((dx == 0) && (dy <= rr[f]))
            || ((dy == 0) && (dx <= rr[f]))
            || ((dx == dy) && (dx <= dd[f]));
    endfunction

    task automatic check(input string tag, input logic exp);
        checks++;
        assert (q === exp) else begin
            errors++;
            $error("FAIL %s q=%b expected=%b", tag, q, exp);
        end
    endtask

    // Present an address, let one edge sample it, then settle.
    task automatic apply(input int a);
        address = 12'(a);
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        address = 12'd189;
        #2;
        check("reset_state", 1'b0);
        @(posedge clock);
        #1;
        check("reset_held_edge", 1'b0);
        @(negedge clock);
        reset = 1'b0;

        apply(189);  check("centre_f0", 1'b1);
        apply(0);    check("corner_f0", 1'b0);
        apply(129);  check("arm_end_f0", 1'b1);
        apply(109);  check("arm_past_f0", 1'b0);
        apply(652);  check("diag_f1", 1'b1);
        apply(673);  check("diag_past_f1", 1'b0);
        apply(809);  check("arm_top_f2", 1'b1);
        apply(1600); check("oor_1600", 1'b0);
        apply(4095); check("oor_4095", 1'b0);

        apply(189);  check("b2b_0", 1'b1);
        apply(0);    check("b2b_1", 1'b0);
        apply(189);  check("b2b_2", 1'b1);

        // Output must not follow address between edges.
        address = 12'd0;
        #2;
        check("no_comb_path", 1'b1);
        address = 12'd189;
        @(posedge clock);
        #1;
        check("hold_189", 1'b1);

        // Asynchronous reset in mid-cycle.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_release_hold", 1'b0);
        @(posedge clock);
        #1;
        check("after_reset", 1'b1);

        for (int a = 0; a < 1600; a++) begin
            apply(a);
            check($sformatf("sweep_%0d", a), model(a));
        end

        for (int i = 0; i < 400; i++) begin
            int a;
            a = int'($urandom_range(0, 4095));
            apply(a);
            check($sformatf("rand_%0d", a), model(a));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
